ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_decode.sv | 71 +++++++
 rtl/ctrl_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, state encoding,
// control-word bit positions and per-opcode instruction lengths.
package ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // Opcodes are held at 8 bits so any legal OPCODE_W zero-extends into them.
    localparam logic [7:0] OP_NOP = 8'd0;
    localparam logic [7:0] OP_LDA = 8'd1;
    localparam logic [7:0] OP_ADD = 8'd2;
    localparam logic [7:0] OP_SUB = 8'd3;
    localparam logic [7:0] OP_STA = 8'd4;
    localparam logic [7:0] OP_LDI = 8'd5;
    localparam logic [7:0] OP_JMP = 8'd6;
    localparam logic [7:0] OP_JC  = 8'd7;
    localparam logic [7:0] OP_JZ  = 8'd8;
    localparam logic [7:0] OP_JNC = 8'd9;
    localparam logic [7:0] OP_JNZ = 8'd10;
    localparam logic [7:0] OP_OUT = 8'd14;
    localparam logic [7:0] OP_HLT = 8'd15;

    localparam int CB_HLT        = 15;
    localparam int CB_PC_INC     = 14;
    localparam int CB_PC_LOAD    = 13;
    localparam int CB_PC_EN      = 12;
    localparam int CB_MAR_LOAD   = 11;
    localparam int CB_MEM_ST     = 10;
    localparam int CB_MEM_EN     = 9;
    localparam int CB_IR_LOAD    = 8;
    localparam int CB_IR_EN      = 7;
    localparam int CB_A_LOAD     = 6;
    localparam int CB_A_EN       = 5;
    localparam int CB_B_LOAD     = 4;
    localparam int CB_ADDER_SUB  = 3;
    localparam int CB_ADDER_EN   = 2;
    localparam int CB_FLAGS_LOAD = 1;
    localparam int CB_OUT_LOAD   = 0;

    localparam int unsigned LAST_SHORT = 3;
    localparam int unsigned LAST_MEM   = 4;
    localparam int unsigned LAST_ALU   = 5;

    function automatic logic [15:0] cbit(input int idx);
        return 16'(1) << idx;
    endfunction

    function automatic int unsigned last_step_of(input logic [7:0] op);
        case (op)
            OP_LDA, OP_STA: return LAST_MEM;
            OP_ADD, OP_SUB: return LAST_ALU;
            default:        return LAST_SHORT;
        endcase
    endfunction

    function automatic logic is_defined(input logic [7:0] op);
        case (op)
            OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP,
            OP_JC, OP_JZ, OP_JNC, OP_JNZ, OP_OUT, OP_HLT: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode ROM: (stage, opcode, flags) -> control word,
// instruction length and undefined-opcode indication.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int FLAG_W   = 2,
    parameter int STAGE_W  = 3
) (
    input  logic [STAGE_W-1:0]  stage,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   flags,
    output logic [15:0]         ctrl,
    output logic [STAGE_W-1:0]  last_step,
    output logic                illegal_op
);

    logic [7:0] op;
    logic       carry;
    logic       zero;

    assign op    = 8'(opcode);
    assign carry = flags[1];
    assign zero  = flags[0];

    assign last_step  = STAGE_W'(last_step_of(op));
    assign illegal_op = !is_defined(op);

    always_comb begin
        // NOTE: default first so every path assigns ctrl and no latch is inferred.
        ctrl = '0;
        case (stage)
            STAGE_W'(0): ctrl = cbit(CB_PC_EN) | cbit(CB_MAR_LOAD);
            STAGE_W'(1): ctrl = cbit(CB_PC_INC);
            STAGE_W'(2): ctrl = cbit(CB_MEM_EN) | cbit(CB_IR_LOAD);
            STAGE_W'(3): begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cbit(CB_IR_EN) | cbit(CB_MAR_LOAD);
                    OP_LDI: ctrl = cbit(CB_IR_EN) | cbit(CB_A_LOAD);
                    OP_JMP: ctrl = cbit(CB_IR_EN) | cbit(CB_PC_LOAD);
                    OP_JC:  if (carry)  ctrl = cbit(CB_IR_EN) | cbit(CB_PC_LOAD);
                    OP_JZ:  if (zero)   ctrl = cbit(CB_IR_EN) | cbit(CB_PC_LOAD);
                    OP_JNC: if (!carry) ctrl = cbit(CB_IR_EN) | cbit(CB_PC_LOAD);
                    OP_JNZ: if (!zero)  ctrl = cbit(CB_IR_EN) | cbit(CB_PC_LOAD);
                    OP_OUT: ctrl = cbit(CB_A_EN) | cbit(CB_OUT_LOAD);
                    OP_HLT: ctrl = cbit(CB_HLT);
                    default: ;
                endcase
            end
            STAGE_W'(4): begin
                case (op)
                    OP_LDA:         ctrl = cbit(CB_MEM_EN) | cbit(CB_A_LOAD);
                    OP_ADD, OP_SUB: ctrl = cbit(CB_MEM_EN) | cbit(CB_B_LOAD);
                    OP_STA:         ctrl = cbit(CB_A_EN) | cbit(CB_MEM_ST);
                    default: ;
                endcase
            end
            STAGE_W'(5): begin
                case (op)
                    OP_ADD: ctrl = cbit(CB_ADDER_EN) | cbit(CB_A_LOAD) | cbit(CB_FLAGS_LOAD);
                    OP_SUB: ctrl = cbit(CB_ADDER_EN) | cbit(CB_A_LOAD) | cbit(CB_FLAGS_LOAD)
                                 | cbit(CB_ADDER_SUB);
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Microstep sequencer: stage counter and RUN/HALTED state, updated on the
// falling edge so the datapath sees a stable control word at each rising edge.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int FLAG_W     = 2,
    parameter int MAX_STAGES = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          resume,
    input  logic [FLAG_W-1:0]             flags,
    input  logic [OPCODE_W-1:0]           opcode,
    output logic [15:0]                   ctrl,
    output logic [$clog2(MAX_STAGES)-1:0] stage,
    output logic                          halted,
    output logic                          illegal
);

    localparam int STAGE_W = $clog2(MAX_STAGES);
    localparam logic [STAGE_W-1:0] STAGE_MAX = STAGE_W'(MAX_STAGES - 1);

    state_t             state, state_nx;
    logic [STAGE_W-1:0] stage_nx;
    logic               illegal_nx;
    logic [STAGE_W-1:0] dec_stage;
    logic [15:0]        dec_ctrl;
    logic [STAGE_W-1:0] last_step;
    logic               illegal_op;

    // While rst is held the datapath already sees the fetch decode.
    assign dec_stage = rst ? '0 : stage;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FLAG_W   (FLAG_W),
        .STAGE_W  (STAGE_W)
    ) u_decode (
        .stage      (dec_stage),
        .opcode     (opcode),
        .flags      (flags),
        .ctrl       (dec_ctrl),
        .last_step  (last_step),
        .illegal_op (illegal_op)
    );

    assign halted = (state == ST_HALTED);
    assign ctrl   = (halted && !rst) ? cbit(CB_HLT) : dec_ctrl;

    always_comb begin
        state_nx   = state;
        stage_nx   = stage;
        illegal_nx = illegal;
        if (run) begin
            case (state)
                ST_RUN: begin
                    if (dec_ctrl[CB_HLT]) begin
                        state_nx = ST_HALTED;
                    end else if (stage == last_step || stage == STAGE_MAX) begin
                        stage_nx = '0;
                        if (illegal_op) illegal_nx = 1'b1;
                    end else begin
                        stage_nx = stage + STAGE_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state_nx = ST_RUN;
                        stage_nx = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so all updates land together.
    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            stage   <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            stage   <= stage_nx;
            illegal <= illegal_nx;
        end
    end

endmodule
